// File: rtl/addsub_acc_ctrl.sv
// Accumulator/controller around an external combinational add/sub unit.
// Streams operands through acc = acc +/- operand and returns the result with sticky error flags.
module addsub_acc_ctrl #(
    parameter int WIDTH   = 4,
    parameter int MAX_OPS = 8,
    parameter int CW      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sel,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_carry,
    input  logic             add_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_uerr,
    output logic             out_ovf,
    output logic [CW-1:0]    out_count
);

    typedef enum logic {
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic             r_uerr;
    logic             r_ovf;

    logic             w_accept;
    logic             w_release;
    logic             w_end_seq;
    logic             w_step_uerr;
    logic [CW-1:0]    w_count_inc;

    assign w_accept    = in_valid & in_ready;
    assign w_release   = out_valid & out_ready;
    assign w_count_inc = r_count + CW'(1);
    assign w_end_seq   = in_last | (w_count_inc == CW'(MAX_OPS));
    // Add reports an unsigned error on carry out; subtract on a missing carry (borrow).
    assign w_step_uerr = in_sub ? ~add_carry : add_carry;

    // Adder operands; acc is forced to zero while reset is held so the adder sees a clean start.
    assign add_a   = reset ? '0 : r_acc;
    assign add_b   = in_data;
    assign add_sel = in_sub;

    assign out_result = r_acc;
    assign out_uerr   = r_uerr;
    assign out_ovf    = r_ovf;
    assign out_count  = r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first so no path through the case leaves the signal unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN:   if (w_accept && w_end_seq) w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_RUN;
            default: w_next_state = S_RUN;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_RUN:   in_ready = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || w_release) begin
            r_acc   <= '0;
            r_count <= '0;
            r_uerr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= add_sum;
            r_count <= w_count_inc;
            r_uerr  <= r_uerr | w_step_uerr;
            r_ovf   <= r_ovf | add_overflow;
        end
    end

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Self-checking bench for addsub_acc_ctrl: behavioural adder, integer reference model,
// directed cases followed by randomized sequences.
module tb_addsub_acc_ctrl;

    localparam int WIDTH   = 4;
    localparam int MAX_OPS = 8;
    localparam int CW      = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sub;
    logic             in_last;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_sel;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic             add_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_uerr;
    logic             out_ovf;
    logic [CW-1:0]    out_count;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state, kept as plain integers.
    int m_acc  = 0;
    int m_cnt  = 0;
    int m_uerr = 0;
    int m_ovf  = 0;
    int m_done = 0;

    always #5 clk = ~clk;

    addsub_acc_ctrl #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sub(in_sub), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_sel(add_sel),
        .add_sum(add_sum), .add_carry(add_carry), .add_overflow(add_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_uerr(out_uerr), .out_ovf(out_ovf), .out_count(out_count)
    );

    // Behavioural 4-bit add/sub unit: carry = 1 means carry out (add) or no borrow (sub).
    always_comb begin
        int ua, ub, sa, sb, ures, sres;
        ua = int'(add_a);
        ub = int'(add_b);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        ures = add_sel ? ua - ub : ua + ub;
        sres = add_sel ? sa - sb : sa + sb;
        add_sum      = WIDTH'((ures + 16) % 16);
        add_carry    = add_sel ? (ures >= 0) : (ures > 15);
        add_overflow = (sres < -8) || (sres > 7);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_acc = 0; m_cnt = 0; m_uerr = 0; m_ovf = 0; m_done = 0;
    endtask

    task automatic model_step(input int d, input int s, input int l);
        int u, sa, sd, sr;
        u  = s ? m_acc - d : m_acc + d;
        sa = (m_acc >= 8) ? m_acc - 16 : m_acc;
        sd = (d >= 8) ? d - 16 : d;
        sr = s ? sa - sd : sa + sd;
        if (u < 0 || u > 15) m_uerr = 1;
        if (sr < -8 || sr > 7) m_ovf = 1;
        m_acc = (u + 16) % 16;
        m_cnt++;
        if (l != 0 || m_cnt == MAX_OPS) m_done = 1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid"},  out_valid,  m_done);
        check({tag, "_result"}, out_result, m_acc);
        check({tag, "_uerr"},   out_uerr,   m_uerr);
        check({tag, "_ovf"},    out_ovf,    m_ovf);
        check({tag, "_count"},  out_count,  m_cnt);
    endtask

    // Offer one operand, wait (bounded) for acceptance, then check the captured state.
    task automatic send(input logic [3:0] d, input logic s, input logic l);
        int guard = 0;
        in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_wait", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        check("add_a", add_a, m_acc);
        check("add_b", add_b, d);
        check("add_sel", add_sel, s);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        in_sub   = 1'($urandom);
        in_last  = 1'($urandom);
        model_step(int'(d), int'(s), int'(l));
        if (m_done != 0) check_outputs("seq");
        else check("seq_busy", out_valid, 0);
    endtask

    // Hold the result with out_ready low (offering junk input), then release it.
    task automatic release_result(input int hold);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            @(posedge clk); #1;
            check("hold_in_ready", in_ready, 0);
            check_outputs("hold");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model_clear();
        check("rel_in_ready", in_ready, 1);
        check("rel_valid", out_valid, 0);
        check("rel_acc", add_a, 0);
        check("rel_count", out_count, 0);
        check("rel_flags", {out_uerr, out_ovf}, 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sub = 1'b0;
        in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("reset_add_a", add_a, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        check("idle_add_a", add_a, 0);
        check("idle_count", out_count, 0);

        // 5 + 9 = 14, no errors.
        send(4'd5, 1'b0, 1'b0);
        send(4'd9, 1'b0, 1'b1);
        check("t1_result", out_result, 4'b1110);
        check("t1_flags", {out_uerr, out_ovf}, 2'b00);
        check("t1_count", out_count, 2);
        release_result(0);

        // 6 + 10 wraps to 0 with carry out.
        send(4'd6, 1'b0, 1'b0);
        send(4'd10, 1'b0, 1'b1);
        check("t2_result", out_result, 4'b0000);
        check("t2_flags", {out_uerr, out_ovf}, 2'b10);
        release_result(1);

        // 10 - 6 = 4: no borrow, but -6 - 6 overflows signed.
        send(4'd10, 1'b0, 1'b0);
        send(4'd6, 1'b1, 1'b1);
        check("t3_result", out_result, 4'b0100);
        check("t3_flags", {out_uerr, out_ovf}, 2'b01);
        release_result(0);

        // Sequence terminated by the operand limit rather than in_last.
        for (int i = 0; i < MAX_OPS; i++) send(4'd1, 1'b0, 1'b0);
        check("t4_valid", out_valid, 1);
        check("t4_result", out_result, 4'b1000);
        check("t4_count", out_count, 8);
        check("t4_flags", {out_uerr, out_ovf}, 2'b01);
        release_result(3);

        // Reset mid-sequence discards the partial accumulation.
        send(4'd3, 1'b0, 1'b0);
        send(4'd4, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_reset_add_a", add_a, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        check("mid_reset_ready", in_ready, 1);
        check("mid_reset_count", out_count, 0);
        check("mid_reset_flags", {out_uerr, out_ovf}, 0);
        send(4'd2, 1'b0, 1'b1);
        check("t5_result", out_result, 4'b0010);
        check("t5_count", out_count, 1);
        release_result(0);

        // First subtract from zero negates and borrows.
        send(4'd3, 1'b1, 1'b1);
        check("neg_result", out_result, 4'b1101);
        check("neg_uerr", out_uerr, 1);
        release_result(0);

        // Randomized sequences with idle gaps and random lengths (some exceed MAX_OPS).
        for (int q = 0; q < 30; q++) begin
            int len;
            len = int'($urandom_range(1, 10));
            for (int i = 0; i < len && m_done == 0; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    in_data = 4'($urandom);
                    in_sub  = 1'($urandom);
                    in_last = 1'($urandom);
                    @(posedge clk); #1;
                    check("gap_count", out_count, m_cnt);
                end
                send(4'($urandom), 1'($urandom), (i == len - 1));
            end
            release_result(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
